rv32_mtimer: RTL and testbench

Memory-mapped machine timer and software-interrupt source, sitting directly upstream of the machine trap CSR block.
- Holds 64-bit mtime, 64-bit mtimecmp and the msip bit.
- Drives irq_timer and irq_software into the trap CSR block.
- Register access from the CPU/bus uses a single-cycle request, fixed-latency response port.

---
 rtl/rv32_mtimer_pkg.sv | 16 +
 rtl/rv32_mtimer_presc.sv | 27 ++
 rtl/rv32_mtimer.sv | 149 ++++++++++++++
 tb/tb_rv32_mtimer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mtimer_pkg.sv
// Shared constants for the machine timer: register offsets,
// compare reset value and the bus address type.
package rv32_mtimer_pkg;

  typedef logic [4:0] addr_t;

  localparam addr_t OFF_MSIP        = 5'h00;
  localparam addr_t OFF_MTIMECMP_LO = 5'h08;
  localparam addr_t OFF_MTIMECMP_HI = 5'h0C;
  localparam addr_t OFF_MTIME_LO    = 5'h10;
  localparam addr_t OFF_MTIME_HI    = 5'h14;
  localparam addr_t OFF_PRESC       = 5'h18;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rv32_mtimer_presc.sv
// Prescaler: free-running counter that pulses tick when it reaches presc.
// Ports: clk, rst_n (sync, active-low), presc (divide value), clr (restart), tick.
module rv32_mtimer_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = (cnt == presc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/rv32_mtimer.sv
// Machine timer / software interrupt source with a 1-cycle read port.
// Ports: clk, rst_n (sync, active-low), bus_req/we/addr/wdata in,
//        bus_rvalid/bus_rdata out, irq_timer, irq_software.
// Build option: MTIMER_LATCH_HI_EN adds a tear-free MTIME_HI shadow.
module rv32_mtimer
  import rv32_mtimer_pkg::*;
#(
  parameter int                 PRESC_W     = 16,
  parameter logic [PRESC_W-1:0] RESET_PRESC = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  output logic        irq_timer,
  output logic        irq_software
);

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               msip;
  logic [PRESC_W-1:0] presc;
  logic               tick;

  addr_t a;
  logic  wr;
  logic  rd;
  logic  sel_msip;
  logic  sel_cmp_lo;
  logic  sel_cmp_hi;
  logic  sel_mt_lo;
  logic  sel_mt_hi;
  logic  sel_presc;
  logic  [31:0] rd_val;
  logic  [31:0] mt_hi_rd;

  logic  unused_addr;
  assign unused_addr = ^bus_addr[1:0];

  assign a  = {bus_addr[4:2], 2'b00};
  assign wr = bus_req & bus_we;
  assign rd = bus_req & ~bus_we;

  always_comb begin
    sel_msip   = 1'b0;
    sel_cmp_lo = 1'b0;
    sel_cmp_hi = 1'b0;
    sel_mt_lo  = 1'b0;
    sel_mt_hi  = 1'b0;
    sel_presc  = 1'b0;
    case (a)
      OFF_MSIP:        sel_msip   = 1'b1;
      OFF_MTIMECMP_LO: sel_cmp_lo = 1'b1;
      OFF_MTIMECMP_HI: sel_cmp_hi = 1'b1;
      OFF_MTIME_LO:    sel_mt_lo  = 1'b1;
      OFF_MTIME_HI:    sel_mt_hi  = 1'b1;
      OFF_PRESC:       sel_presc  = 1'b1;
      default: ;
    endcase
  end

  rv32_mtimer_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .presc (presc),
    .clr   (wr & sel_presc),
    .tick  (tick)
  );

  // A write to either mtime half wins over the tick, so no carry
  // crosses halves on a write cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr && sel_mt_lo) begin
      mtime[31:0] <= bus_wdata;
    end else if (wr && sel_mt_hi) begin
      mtime[63:32] <= bus_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
      presc    <= RESET_PRESC;
    end else if (wr) begin
      if (sel_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
      if (sel_cmp_hi) mtimecmp[63:32] <= bus_wdata;
      if (sel_msip)   msip            <= bus_wdata[0];
      if (sel_presc)  presc           <= bus_wdata[PRESC_W-1:0];
    end
  end

`ifdef MTIMER_LATCH_HI_EN
  logic [31:0] mt_hi_shadow;

  // LO read captures the matching upper half for a tear-free LO->HI pair.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mt_hi_shadow <= '0;
    end else if (wr && sel_mt_hi) begin
      mt_hi_shadow <= bus_wdata;
    end else if (rd && sel_mt_lo) begin
      mt_hi_shadow <= mtime[63:32];
    end
  end

  assign mt_hi_rd = mt_hi_shadow;
`else
  assign mt_hi_rd = mtime[63:32];
`endif

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_msip:   rd_val = {31'b0, msip};
      sel_cmp_lo: rd_val = mtimecmp[31:0];
      sel_cmp_hi: rd_val = mtimecmp[63:32];
      sel_mt_lo:  rd_val = mtime[31:0];
      sel_mt_hi:  rd_val = mt_hi_rd;
      sel_presc:  rd_val = 32'(presc);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_rvalid   <= 1'b0;
      bus_rdata    <= '0;
      irq_timer    <= 1'b0;
      irq_software <= 1'b0;
    end else begin
      bus_rvalid   <= rd;
      irq_timer    <= (mtime >= mtimecmp);
      irq_software <= msip;
      if (rd) bus_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_rv32_mtimer.sv
// Self-checking bench for rv32_mtimer: directed vector table plus
// hand-written multi-cycle sequences.
module tb_rv32_mtimer;

  logic        clk;
  logic        rst_n;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        irq_timer;
  logic        irq_software;

  localparam logic [4:0] A_MSIP  = 5'h00;
  localparam logic [4:0] A_CLO   = 5'h08;
  localparam logic [4:0] A_CHI   = 5'h0C;
  localparam logic [4:0] A_MLO   = 5'h10;
  localparam logic [4:0] A_MHI   = 5'h14;
  localparam logic [4:0] A_PRESC = 5'h18;

  int total = 0;
  int bad   = 0;

  rv32_mtimer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .irq_timer    (irq_timer),
    .irq_software (irq_software)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] ad, input logic [31:0] d);
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = ad;
    bus_wdata = d;
    cyc();
    bus_req = 1'b0;
    bus_we  = 1'b0;
    chk("wr_rvalid", 64'(bus_rvalid), 64'd0);
  endtask

  task automatic bus_read(input logic [4:0] ad, output logic [31:0] d);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = ad;
    cyc();
    bus_req = 1'b0;
    d = bus_rdata;
    chk("rd_rvalid", 64'(bus_rvalid), 64'd1);
  endtask

  logic [31:0] d;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] exp_hi;

  initial begin
    tbl[0]  = '{1'b1, A_MSIP,  32'hFFFF_FFFF, 32'h0};
    tbl[1]  = '{1'b0, A_MSIP,  32'h0,         32'h1};
    tbl[2]  = '{1'b1, A_MSIP,  32'h0,         32'h0};
    tbl[3]  = '{1'b0, A_MSIP,  32'h0,         32'h0};
    tbl[4]  = '{1'b1, A_CLO,   32'h1234_5678, 32'h0};
    tbl[5]  = '{1'b1, A_CHI,   32'h9ABC_DEF0, 32'h0};
    tbl[6]  = '{1'b0, A_CLO,   32'h0,         32'h1234_5678};
    tbl[7]  = '{1'b0, 5'h0F,   32'h0,         32'h9ABC_DEF0};
    tbl[8]  = '{1'b1, A_PRESC, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{1'b0, A_PRESC, 32'h0,         32'h0000_FFFF};
    tbl[10] = '{1'b1, A_PRESC, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 5'h04,   32'h0,         32'h0};
    tbl[12] = '{1'b1, 5'h1C,   32'h5,         32'h0};
    tbl[13] = '{1'b0, 5'h1C,   32'h0,         32'h0};

    rst_n     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    cyc();
    cyc();
    chk("rst_rvalid", 64'(bus_rvalid), 64'd0);
    chk("rst_rdata", 64'(bus_rdata), 64'd0);
    chk("rst_irq_t", 64'(irq_timer), 64'd0);
    chk("rst_irq_s", 64'(irq_software), 64'd0);
    rst_n = 1'b1;

    repeat (10) cyc();
    bus_read(A_MLO, d);
    chk("idle10_lo", 64'(d), 64'd10);
    bus_read(A_MHI, d);
    chk("idle10_hi", 64'(d), 64'd0);
    chk("idle_irq_t", 64'(irq_timer), 64'd0);
    chk("idle_irq_s", 64'(irq_software), 64'd0);

    bus_write(A_PRESC, 32'd3);
    bus_read(A_MLO, a0);
    repeat (39) cyc();
    bus_read(A_MLO, b0);
    chk("presc3_delta", 64'(b0 - a0), 64'd10);
    bus_read(A_PRESC, d);
    chk("presc3_rd", 64'(d), 64'd3);
    bus_write(A_PRESC, 32'd0);

    bus_write(A_MHI, 32'd0);
    bus_write(A_MLO, 32'd0);
    bus_write(A_CHI, 32'd0);
    bus_write(A_CLO, 32'd20);
    repeat (18) cyc();
    chk("irq_before", 64'(irq_timer), 64'd0);
    cyc();
    chk("irq_rise", 64'(irq_timer), 64'd1);
    bus_write(A_CLO, 32'd100);
    chk("irq_hold", 64'(irq_timer), 64'd1);
    cyc();
    chk("irq_fall", 64'(irq_timer), 64'd0);

    bus_write(A_MHI, 32'd0);
    bus_write(A_MLO, 32'hFFFF_FFFF);
    bus_read(A_MLO, d);
    chk("carry_lo0", 64'(d), 64'hFFFF_FFFF);
    bus_read(A_MHI, d);
`ifdef MTIMER_LATCH_HI_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    chk("carry_hi0", 64'(d), 64'(exp_hi));
    bus_read(A_MLO, d);
    chk("carry_lo1", 64'(d), 64'd1);
    bus_read(A_MHI, d);
    chk("carry_hi1", 64'(d), 64'd1);

    bus_write(A_MSIP, 32'd1);
    chk("msip_lag", 64'(irq_software), 64'd0);
    cyc();
    chk("msip_set", 64'(irq_software), 64'd1);
    bus_write(A_MSIP, 32'd0);
    chk("msip_lag0", 64'(irq_software), 64'd1);
    cyc();
    chk("msip_clr", 64'(irq_software), 64'd0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].we) begin
        bus_write(tbl[i].addr, tbl[i].wdata);
      end else begin
        bus_read(tbl[i].addr, d);
        chk($sformatf("tbl%0d", i), 64'(d), 64'(tbl[i].exp));
      end
    end

    bus_write(A_MLO, 32'd5);
    bus_read(A_MLO, d);
    chk("wr_wins_lo", 64'(d), 64'd5);
    bus_write(A_MHI, 32'd7);
    bus_read(A_MHI, d);
    chk("wr_hi", 64'(d), 64'd7);
    bus_read(A_MLO, d);
    chk("wr_hi_lo", 64'(d), 64'd7);

    bus_write(A_MSIP, 32'd1);
    bus_write(A_CHI, 32'd0);
    bus_write(A_CLO, 32'd0);
    cyc();
    chk("pre_rst_t", 64'(irq_timer), 64'd1);
    chk("pre_rst_s", 64'(irq_software), 64'd1);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = A_MLO;
    rst_n    = 1'b0;
    cyc();
    bus_req = 1'b0;
    chk("mid_rst_rvalid", 64'(bus_rvalid), 64'd0);
    chk("mid_rst_rdata", 64'(bus_rdata), 64'd0);
    chk("mid_rst_irq_t", 64'(irq_timer), 64'd0);
    chk("mid_rst_irq_s", 64'(irq_software), 64'd0);
    rst_n = 1'b1;
    bus_read(A_MLO, d);
    chk("post_rst_lo", 64'(d), 64'd0);
    bus_read(A_MHI, d);
    chk("post_rst_hi", 64'(d), 64'd0);
    bus_read(A_CLO, d);
    chk("post_rst_clo", 64'(d), 64'hFFFF_FFFF);
    bus_read(A_CHI, d);
    chk("post_rst_chi", 64'(d), 64'hFFFF_FFFF);
    bus_read(A_MSIP, d);
    chk("post_rst_msip", 64'(d), 64'd0);
    bus_read(A_PRESC, d);
    chk("post_rst_presc", 64'(d), 64'd0);
    chk("post_rst_irq_t", 64'(irq_timer), 64'd0);
    chk("post_rst_irq_s", 64'(irq_software), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
